// File: rtl/cgp_tnn_pkg.sv
// Shared types and arithmetic helpers for the streaming threshold neuron.
package cgp_tnn_pkg;

    // Widest accumulator the helpers handle; callers zero-extend into this width.
    localparam int unsigned CALC_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    // Returns {sat, sum}: sum clamps to 2^acc_w-1 and sat flags the clamp.
    function automatic logic [CALC_W:0] sat_add(
        input logic [CALC_W-1:0] acc,
        input logic [CALC_W-1:0] op,
        input int unsigned       acc_w
    );
        logic [CALC_W:0] sum;
        logic [CALC_W:0] lim;
        sum = {1'b0, acc} + {1'b0, op};
        lim = ({{CALC_W{1'b0}}, 1'b1} << acc_w) - {{CALC_W{1'b0}}, 1'b1};
        if (sum > lim) begin
            return {1'b1, lim[CALC_W-1:0]};
        end
        return {1'b0, sum[CALC_W-1:0]};
    endfunction

    // Clears the low trunc_lsb bits of an operand (approximate mode).
    function automatic logic [CALC_W-1:0] trunc_op(
        input logic [CALC_W-1:0] data,
        input int unsigned       trunc_lsb
    );
        logic [CALC_W-1:0] mask;
        mask = '1;
        mask = mask << trunc_lsb;
        return data & mask;
    endfunction

    // Elaboration-time legality of a parameter set.
    function automatic bit params_ok(
        input int in_w,
        input int acc_w,
        input int trunc_lsb,
        input int max_beats
    );
        return (acc_w >= in_w) && (acc_w <= int'(CALC_W)) && (trunc_lsb >= 0) &&
               (trunc_lsb < in_w) && (max_beats >= 1);
    endfunction

endpackage

// File: rtl/cgp_sat_acc.sv
// Registered saturating accumulator with clear/load/add and a sticky sat flag.
module cgp_sat_acc
    import cgp_tnn_pkg::*;
#(
    parameter int ACC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             add,
    input  logic [ACC_W-1:0] op,
    output logic [ACC_W-1:0] acc,
    output logic             sat,
    output logic [ACC_W-1:0] acc_nxt,
    output logic             sat_nxt
);

    logic [ACC_W-1:0] acc_d, acc_q;
    logic             sat_d, sat_q;
    logic [ACC_W-1:0] add_sum;
    logic             add_sat;

    assign add_sum = ACC_W'(sat_add(CALC_W'(acc_q), CALC_W'(op), ACC_W));
    assign add_sat = 1'(sat_add(CALC_W'(acc_q), CALC_W'(op), ACC_W) >> CALC_W);

    // Next accumulator value: clear beats load beats add.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (load) begin
            acc_d = op;
            sat_d = 1'b0;
        end else if (add) begin
            acc_d = add_sum;
            sat_d = sat_q | add_sat;
        end
    end

    // Accumulator and sticky saturation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc     = acc_q;
    assign sat     = sat_q;
    assign acc_nxt = acc_d;
    assign sat_nxt = sat_d;

endmodule

// File: rtl/cgp_stream_thr_neuron.sv
// Streaming threshold neuron: accumulate operand beats, compare against a
// per-decision threshold, emit a registered decision with saturated sum.
module cgp_stream_thr_neuron
    import cgp_tnn_pkg::*;
#(
    parameter int IN_W      = 3,
    parameter int MAX_BEATS = 8,
    parameter int ACC_W     = 6,
    parameter int TRUNC_LSB = 0,
    parameter int CMP_GE    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [IN_W-1:0]  in_thr,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    if (!params_ok(IN_W, ACC_W, TRUNC_LSB, MAX_BEATS)) begin : g_param_check
        $error("cgp_stream_thr_neuron: illegal parameter combination");
    end

    state_t           state_d, state_q;
    logic             in_ready_d, in_ready_q;
    logic             out_valid_d, out_valid_q;
    logic             out_bit_d, out_bit_q;
    logic             out_ovf_d, out_ovf_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [IN_W-1:0]  thr_d, thr_q;

    logic             beat;
    logic             term;
    logic             acc_clr, acc_load, acc_add;
    logic [ACC_W-1:0] op_ext;
    logic [ACC_W-1:0] acc_cur, acc_nxt;
    logic             sat_cur, sat_nxt;
    logic [ACC_W-1:0] thr_ext;
    logic             decide;

    assign beat   = in_valid & in_ready_q;
    assign op_ext = ACC_W'(trunc_op(CALC_W'(in_data), TRUNC_LSB));

    cgp_sat_acc #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .load   (acc_load),
        .add    (acc_add),
        .op     (op_ext),
        .acc    (acc_cur),
        .sat    (sat_cur),
        .acc_nxt(acc_nxt),
        .sat_nxt(sat_nxt)
    );

    // The decision is registered alongside out_valid, so it is taken from the
    // value the accumulator is about to hold; on a single-beat decision the
    // threshold register is not loaded yet, hence the bypass from in_thr.
    assign thr_ext = ACC_W'((state_q == IDLE) ? in_thr : thr_q);
    assign decide  = (CMP_GE != 0) ? (acc_nxt >= thr_ext) : (acc_nxt > thr_ext);

    // FSM next-state, accumulator control and next registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        thr_d     = thr_q;
        out_bit_d = out_bit_q;
        out_ovf_d = out_ovf_q;
        term      = 1'b0;
        acc_clr   = 1'b0;
        acc_load  = 1'b0;
        acc_add   = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_load = 1'b1;
                    thr_d    = in_thr;
                    cnt_d    = CNT_W'(1);
                    if (in_last || (MAX_BEATS == 1)) begin
                        term = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (beat) begin
                    acc_add = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (in_last || (cnt_q + CNT_W'(1) == CNT_W'(MAX_BEATS))) begin
                        term = 1'b1;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d   = IDLE;
                    acc_clr   = 1'b1;
                    cnt_d     = '0;
                    thr_d     = '0;
                    out_bit_d = 1'b0;
                    out_ovf_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (term) begin
            state_d   = OUT;
            out_bit_d = decide;
            out_ovf_d = sat_nxt | ((cnt_d == CNT_W'(MAX_BEATS)) & ~in_last);
        end
        in_ready_d  = (state_d != OUT);
        out_valid_d = (state_d == OUT);
    end

    // FSM state and registered handshake/decision outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
            cnt_q       <= '0;
            thr_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_ovf_q   <= out_ovf_d;
            cnt_q       <= cnt_d;
            thr_q       <= thr_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_ovf   = out_ovf_q;
    assign out_sum   = acc_cur;

    // Sticky sat is consumed through sat_nxt at termination only.
    logic unused_sat;
    assign unused_sat = sat_cur;

endmodule

// File: tb/tb_cgp_stream_thr_neuron.sv
// Self-checking bench: four instances in lockstep (default, CMP_GE=0,
// ACC_W=4, TRUNC_LSB=1) sharing one input stream, scoreboard of expectations.
module tb_cgp_stream_thr_neuron;

    typedef struct packed {
        logic       b;
        logic [5:0] s;
        logic       o;
    } res_t;
    typedef res_t [3:0] res4_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = '0;
    logic [2:0] in_thr = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic [3:0] rdy, ov, ob, of;
    logic [5:0] os0, os1, os3;
    logic [3:0] os2;

    int    vectors = 0;
    int    miscompares = 0;
    res4_t sb[$];

    always #5 clk = ~clk;

    cgp_stream_thr_neuron #(.IN_W(3), .MAX_BEATS(8), .ACC_W(6), .TRUNC_LSB(0), .CMP_GE(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .in_thr(in_thr), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
        .out_bit(ob[0]), .out_sum(os0), .out_ovf(of[0]));
    cgp_stream_thr_neuron #(.IN_W(3), .MAX_BEATS(8), .ACC_W(6), .TRUNC_LSB(0), .CMP_GE(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .in_thr(in_thr), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
        .out_bit(ob[1]), .out_sum(os1), .out_ovf(of[1]));
    cgp_stream_thr_neuron #(.IN_W(3), .MAX_BEATS(8), .ACC_W(4), .TRUNC_LSB(0), .CMP_GE(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .in_thr(in_thr), .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready),
        .out_bit(ob[2]), .out_sum(os2), .out_ovf(of[2]));
    cgp_stream_thr_neuron #(.IN_W(3), .MAX_BEATS(8), .ACC_W(6), .TRUNC_LSB(1), .CMP_GE(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
        .in_thr(in_thr), .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready),
        .out_bit(ob[3]), .out_sum(os3), .out_ovf(of[3]));

    function automatic res_t obs(input int v);
        res_t r;
        case (v)
            0:       begin r.b = ob[0]; r.s = os0;           r.o = of[0]; end
            1:       begin r.b = ob[1]; r.s = os1;           r.o = of[1]; end
            2:       begin r.b = ob[2]; r.s = {2'b00, os2};  r.o = of[2]; end
            default: begin r.b = ob[3]; r.s = os3;           r.o = of[3]; end
        endcase
        return r;
    endfunction

    // Reference model of one decision for one configuration.
    function automatic res_t model(input int n, input logic [2:0] d[8], input int thr,
                                   input bit last, input int accw, input int trunc, input bit ge);
        int   acc, mx, op;
        bit   sat;
        res_t r;
        acc = 0;
        sat = 1'b0;
        mx  = (1 << accw) - 1;
        for (int i = 0; i < n; i++) begin
            op = int'(d[i]) & ~((1 << trunc) - 1);
            if (acc + op > mx) begin
                acc = mx;
                sat = 1'b1;
            end else begin
                acc = acc + op;
            end
        end
        r.s = 6'(acc);
        r.b = ge ? (acc >= thr) : (acc > thr);
        r.o = sat | ((n == 8) && !last);
        return r;
    endfunction

    function automatic res4_t predict(input int n, input logic [2:0] d[8], input int thr, input bit last);
        res4_t e;
        e[0] = model(n, d, thr, last, 6, 0, 1'b1);
        e[1] = model(n, d, thr, last, 6, 0, 1'b0);
        e[2] = model(n, d, thr, last, 4, 0, 1'b1);
        e[3] = model(n, d, thr, last, 6, 1, 1'b1);
        return e;
    endfunction

    // Drive n beats starting at a negedge; returns at the negedge after the
    // last accepted beat. Pushes the expectation if the decision terminates.
    task automatic send(input int n, input logic [2:0] d[8], input logic [2:0] thr, input bit last);
        int guard;
        if (last || n == 8) sb.push_back(predict(n, d, int'(thr), last));
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            in_thr   = (i == 0) ? thr : 3'($urandom);
            in_last  = last && (i == n - 1);
            guard = 0;
            while (rdy[0] !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            vectors++;
            if (guard >= 20) begin
                miscompares++;
                $display("FAIL beat_accept: in_ready=%b after %0d cycles, want 1", rdy[0], guard);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        for (int v = 0; v < 4; v++) begin
            vectors++;
            if (rdy[v] !== 1'b0 || ov[v] !== 1'b0 || obs(v) !== '0) begin
                miscompares++;
                $display("FAIL reset_vals v%0d: rdy=%b ov=%b res=%h want 0/0/0", v, rdy[v], ov[v], obs(v));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (rdy !== 4'hf) begin
            miscompares++;
            $display("FAIL reset_ready: in_ready=%b want 1111", rdy);
        end
    endtask

    task automatic test_basic();
        logic [2:0] d[8];
        res4_t e;
        res_t  o;
        d = '{3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send(2, d, 3'd5, 1'b1);
        vectors++;
        if (ov !== 4'hf) begin
            miscompares++;
            $display("FAIL basic_latency: out_valid=%b want 1111", ov);
        end
        e = sb.pop_front();
        for (int v = 0; v < 4; v++) begin
            o = obs(v);
            vectors++;
            if (o !== e[v]) begin
                miscompares++;
                $display("FAIL basic v%0d: bit/sum/ovf=%b/%0d/%b want %b/%0d/%b", v, o.b, o.s, o.o, e[v].b, e[v].s, e[v].o);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_forced(input bit last);
        logic [2:0] d[8];
        res4_t e;
        res_t  o;
        d = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        send(8, d, 3'd7, last);
        vectors++;
        if (ov !== 4'hf || rdy !== 4'h0) begin
            miscompares++;
            $display("FAIL forced_term: out_valid=%b in_ready=%b want 1111/0000", ov, rdy);
        end
        e = sb.pop_front();
        for (int v = 0; v < 4; v++) begin
            o = obs(v);
            vectors++;
            if (o !== e[v]) begin
                miscompares++;
                $display("FAIL forced last=%0b v%0d: bit/sum/ovf=%b/%0d/%b want %b/%0d/%b", last, v, o.b, o.s, o.o, e[v].b, e[v].s, e[v].o);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sat_trunc();
        logic [2:0] d[8];
        res4_t e;
        res_t  o;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                d = '{3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
                send(3, d, 3'd7, 1'b1);
            end else begin
                d = '{3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
                send(2, d, 3'd3, 1'b1);
            end
            e = sb.pop_front();
            for (int v = 0; v < 4; v++) begin
                o = obs(v);
                vectors++;
                if (ov[v] !== 1'b1 || o !== e[v]) begin
                    miscompares++;
                    $display("FAIL sat_trunc k%0d v%0d: valid=%b bit/sum/ovf=%b/%0d/%b want 1 %b/%0d/%b", k, v, ov[v], o.b, o.s, o.o, e[v].b, e[v].s, e[v].o);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] d[8];
        res4_t e;
        res_t  o;
        d = '{3'd4, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        out_ready = 1'b0;
        send(2, d, 3'd6, 1'b1);
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 3'($urandom);
            in_thr   = 3'd0;
            in_last  = 1'b1;
            for (int v = 0; v < 4; v++) begin
                o = obs(v);
                vectors++;
                if (ov[v] !== 1'b1 || rdy[v] !== 1'b0 || o !== e[v]) begin
                    miscompares++;
                    $display("FAIL hold c%0d v%0d: valid=%b rdy=%b res=%h want 1/0/%h", c, v, ov[v], rdy[v], o, e[v]);
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdy !== 4'hf || ov !== 4'h0) begin
            miscompares++;
            $display("FAIL release: in_ready=%b out_valid=%b want 1111/0000", rdy, ov);
        end
        d = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send(2, d, 3'd2, 1'b1);
        e = sb.pop_front();
        for (int v = 0; v < 4; v++) begin
            o = obs(v);
            vectors++;
            if (o !== e[v]) begin
                miscompares++;
                $display("FAIL fresh_thr v%0d: bit/sum/ovf=%b/%0d/%b want %b/%0d/%b", v, o.b, o.s, o.o, e[v].b, e[v].s, e[v].o);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [2:0] d[8];
        res4_t e;
        res_t  o;
        d = '{3'd5, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send(2, d, 3'd3, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if (ov !== 4'h0) begin
            miscompares++;
            $display("FAIL rst_acc_valid: out_valid=%b want 0000", ov);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send(1, d, 3'd1, 1'b1);
        e = sb.pop_front();
        for (int v = 0; v < 4; v++) begin
            o = obs(v);
            vectors++;
            if (ov[v] !== 1'b1 || o !== e[v]) begin
                miscompares++;
                $display("FAIL no_residue v%0d: valid=%b bit/sum/ovf=%b/%0d/%b want 1 %b/%0d/%b", v, ov[v], o.b, o.s, o.o, e[v].b, e[v].s, e[v].o);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        d = '{3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send(2, d, 3'd2, 1'b1);
        e = sb.pop_front();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (ov !== 4'h0 || of !== 4'h0 || ob !== 4'h0) begin
            miscompares++;
            $display("FAIL rst_out_async: out_valid=%b ovf=%b bit=%b want 0000 all", ov, of, ob);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (rdy !== 4'hf || ov !== 4'h0) begin
            miscompares++;
            $display("FAIL rst_out_recover: in_ready=%b out_valid=%b want 1111/0000", rdy, ov);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] d[8];
        res4_t e;
        res_t  o;
        int    n;
        bit    last;
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 8);
            last = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) d[i] = 3'($urandom);
            send(n, d, 3'($urandom), last);
            e = sb.pop_front();
            for (int v = 0; v < 4; v++) begin
                o = obs(v);
                vectors++;
                if (ov[v] !== 1'b1 || o !== e[v]) begin
                    miscompares++;
                    $display("FAIL b2b k%0d n%0d v%0d: valid=%b bit/sum/ovf=%b/%0d/%b want 1 %b/%0d/%b", k, n, v, ov[v], o.b, o.s, o.o, e[v].b, e[v].s, e[v].o);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forced(1'b0);
        test_forced(1'b1);
        test_sat_trunc();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
